du_dmem_rx: RTL and testbench
=============================

Name: du_dmem_rx

Overview:
Debug-unit data-memory loader: receive path of the UART debug protocol, complementary to the data-memory dump path. It pulls 4-byte address/data pairs from the UART Rx FIFO and issues word writes into data memory. The sequence ends with address 0xFFFF_FFFF. It sits between the debug unit's top-level command FSM and the data memory write port, and shares the UART FIFO signalling used by the other debug sub-blocks.

Parameters:
NB_DATA, 32, data memory address/data width
NB_UART_DATA, 8, UART byte width
ACK_BYTE, 8'h06, byte sent after each completed write (optional feature only)

Ports:
clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  start pulse from debug command FSM; sampled only in IDLE
i_rx_done  input  1  UART Rx FIFO not empty; byte available on i_rx_data
i_rx_data  input  NB_UART_DATA  UART Rx FIFO head byte
i_tx_done  input  1  UART Tx finished current byte
o_done  output  1  one-cycle pulse: terminator received, loader finished
o_rd  output  1  UART Rx FIFO read enable (pop)
o_dmem_wr  output  1  data memory write enable
o_dmem_wsize  output  2  write size; 2'b11 = word
o_dmem_waddr  output  NB_DATA  write address
o_dmem_wdata  output  NB_DATA  write data
o_wr  output  1  UART Tx FIFO write enable
o_tx_start  output  1  UART Tx start
o_wdata  output  NB_UART_DATA  UART Tx FIFO write data

Behaviour:
- Registers: state, addr_reg[NB_DATA], data_reg[NB_DATA], cnt_reg[3]. All are cleared on i_rst, and state goes to IDLE.
- All outputs are combinational from state/registers (o_rd also depends on i_rx_done). Every output defaults to 0 in every state unless listed below. All outputs are 0 in the cycle after reset.
- Reset mid-operation aborts immediately. No write is issued and partial address/data is discarded.
- IDLE: on i_start go to RX_ADDR with cnt=0. i_start is ignored in every other state.
- RX_ADDR, when cnt<4 and i_rx_done=1:
  - o_rd=1 in the same cycle.
  - addr_next = {i_rx_data, addr_reg[NB_DATA-1:NB_UART_DATA]}, so bytes arrive LSB first.
  - cnt++.
- RX_ADDR, when cnt==4: no pop; cnt cleared.
  - If addr_reg==32'hFFFF_FFFF: o_done=1 for this single cycle, next state IDLE.
  - Otherwise next state RX_DATA.
- RX_DATA: same byte assembly into data_reg, LSB first. At cnt==4, cnt is cleared and the next state is WRITE. No terminator check is done on data.
- WRITE (exactly one cycle):
  - o_dmem_wr=1, o_dmem_wsize=2'b11, o_dmem_waddr=addr_reg, o_dmem_wdata=data_reg.
  - Next state is ACK if the feature is enabled, otherwise RX_ADDR.
- Latency: the 4th data byte is popped in cycle N; RX_DATA sees cnt==4 in cycle N+1; o_dmem_wr=1 in cycle N+2.
- Addresses pass through unmodified. No alignment check; the memory handles it.
- Pipelining: the address register is not cleared between pairs; it is fully overwritten by 4 new bytes. Back-to-back pairs need no idle gap beyond the FSM states.
- FIFO empty: while i_rx_done=0 the FSM holds in its RX state; no pop and no count.
- No overflow exists: o_rd is only asserted with i_rx_done=1.

Optional Feature:
Macro DU_DMEM_RX_ACK_EN.
- Defined: ACK state is present.
  - On entry cycle (ack_sent=0): o_wr=1, o_tx_start=1, o_wdata=ACK_BYTE; set ack_sent.
  - Then hold until i_tx_done=1, then clear ack_sent and go to RX_ADDR.
  - The terminator does not generate an ACK.
- Not defined: no ACK state and no ack_sent register. WRITE returns directly to RX_ADDR, and o_wr, o_tx_start and o_wdata are tied to 0.

Test Plan:
- Reset then i_start; feed bytes 10 00 00 00, EF BE AD DE -> one o_dmem_wr pulse with waddr=0x0000_0010, wdata=0xDEAD_BEEF, wsize=2'b11; 8 o_rd pulses; wr exactly 2 cycles after the last data pop.
- Two back-to-back pairs (0x4 -> 0x1111_1111, 0x8 -> 0x2222_2222), then FF FF FF FF -> two correct writes, then o_done high for exactly 1 cycle; state returns to IDLE; a further byte on i_rx_done is not popped.
- i_rx_done gapped randomly (1 byte every 3-7 cycles) -> identical writes and no o_rd while i_rx_done=0.
- Assert i_rst after 2 address bytes, then restart with a full pair 20 00 00 00 / 01 00 00 00 -> only write is addr 0x20, data 0x1; no stale bytes.
- Data word 0xFFFF_FFFF with addr 0x0C -> normal write (no termination).
- With DU_DMEM_RX_ACK_EN: after each write, o_wr/o_tx_start pulse once with o_wdata=8'h06; next address byte is not popped until i_tx_done=1. Without the macro: o_wr stays 0 throughout.

Source files
------------

// File: rtl/du_dmem_rx.sv
// -----------------------------------------------------------------------------
// du_dmem_rx
//   Debug-unit data-memory loader (UART receive side). After a start pulse it
//   pulls 4-byte address / 4-byte data pairs from the UART Rx FIFO, LSB first,
//   and issues one word write to data memory per pair. An address of
//   0xFFFF_FFFF ends the sequence: o_done pulses and the block returns to IDLE.
//
//   Optional feature, macro DU_DMEM_RX_ACK_EN: after every completed write an
//   ACK_BYTE is pushed into the UART Tx FIFO, and the loader waits for
//   i_tx_done before it accepts the next address. The terminator is not
//   acknowledged. Without the macro, the Tx outputs are tied to zero.
//
// Parameters
//   NB_DATA       address / data width of the data memory port
//   NB_UART_DATA  UART byte width
//   ACK_BYTE      byte sent after each completed write (ACK build only)
//
// Ports
//   clk           clock
//   i_rst         synchronous active-high reset; aborts any pair in flight
//   i_start       start pulse from the command FSM, only looked at in IDLE
//   i_rx_done     Rx FIFO not empty, i_rx_data holds the head byte
//   i_rx_data     Rx FIFO head byte
//   i_tx_done     Tx finished the current byte
//   o_done        one-cycle pulse once the terminator address is received
//   o_rd          Rx FIFO pop; only ever raised together with i_rx_done
//   o_dmem_wr     data memory write enable (one cycle per pair)
//   o_dmem_wsize  write size, always word (2'b11) when writing
//   o_dmem_waddr  write address
//   o_dmem_wdata  write data
//   o_wr          Tx FIFO write enable
//   o_tx_start    Tx start
//   o_wdata       Tx FIFO write data
// -----------------------------------------------------------------------------
module du_dmem_rx #(
  parameter int                      NB_DATA      = 32,
  parameter int                      NB_UART_DATA = 8,
  parameter logic [NB_UART_DATA-1:0] ACK_BYTE     = 8'h06
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_rx_done,
  input  logic [NB_UART_DATA-1:0] i_rx_data,
  input  logic                    i_tx_done,
  output logic                    o_done,
  output logic                    o_rd,
  output logic                    o_dmem_wr,
  output logic [1:0]              o_dmem_wsize,
  output logic [NB_DATA-1:0]      o_dmem_waddr,
  output logic [NB_DATA-1:0]      o_dmem_wdata,
  output logic                    o_wr,
  output logic                    o_tx_start,
  output logic [NB_UART_DATA-1:0] o_wdata
);

  localparam logic [2:0]         BYTES_PER_WORD = 3'd4;
  localparam logic [1:0]         WSIZE_WORD     = 2'b11;
  localparam logic [NB_DATA-1:0] TERM_ADDR      = '1;

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_DATA,
`ifdef DU_DMEM_RX_ACK_EN
    ACK,
`endif
    WRITE
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [2:0]         cnt_q, cnt_d;

`ifdef DU_DMEM_RX_ACK_EN
  logic                    ack_sent_q, ack_sent_d;
  logic                    wr_c, tx_start_c;
  logic [NB_UART_DATA-1:0] wdata_c;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DU_DMEM_RX_ACK_EN
  always_ff @(posedge clk) begin
    if (i_rst) ack_sent_q <= 1'b0;
    else       ack_sent_q <= ack_sent_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    o_done       = 1'b0;
    o_rd         = 1'b0;
    o_dmem_wr    = 1'b0;
    o_dmem_wsize = 2'b00;
    o_dmem_waddr = '0;
    o_dmem_wdata = '0;
`ifdef DU_DMEM_RX_ACK_EN
    ack_sent_d   = ack_sent_q;
    wr_c         = 1'b0;
    tx_start_c   = 1'b0;
    wdata_c      = '0;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RX_ADDR;
          cnt_d   = '0;
        end
      end

      RX_ADDR: begin
        // The address register is only tested once all four bytes are in;
        // the previous pair's value is fully shifted out by then.
        if (cnt_q == BYTES_PER_WORD) begin
          cnt_d = '0;
          if (addr_q == TERM_ADDR) begin
            o_done  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RX_DATA;
          end
        end else if (i_rx_done) begin
          o_rd   = 1'b1;
          addr_d = {i_rx_data, addr_q[NB_DATA-1:NB_UART_DATA]};
          cnt_d  = cnt_q + 3'd1;
        end
      end

      RX_DATA: begin
        // No terminator check here: all-ones is a legal data word.
        if (cnt_q == BYTES_PER_WORD) begin
          cnt_d   = '0;
          state_d = WRITE;
        end else if (i_rx_done) begin
          o_rd   = 1'b1;
          data_d = {i_rx_data, data_q[NB_DATA-1:NB_UART_DATA]};
          cnt_d  = cnt_q + 3'd1;
        end
      end

      WRITE: begin
        o_dmem_wr    = 1'b1;
        o_dmem_wsize = WSIZE_WORD;
        o_dmem_waddr = addr_q;
        o_dmem_wdata = data_q;
`ifdef DU_DMEM_RX_ACK_EN
        state_d      = ACK;
`else
        state_d      = RX_ADDR;
`endif
      end

`ifdef DU_DMEM_RX_ACK_EN
      ACK: begin
        // The byte is queued in the entry cycle only; after that the
        // loader waits for the transmitter, which keeps the host from
        // running ahead of the memory writes.
        if (!ack_sent_q) begin
          wr_c       = 1'b1;
          tx_start_c = 1'b1;
          wdata_c    = ACK_BYTE;
          ack_sent_d = 1'b1;
        end else if (i_tx_done) begin
          ack_sent_d = 1'b0;
          state_d    = RX_ADDR;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

`ifdef DU_DMEM_RX_ACK_EN
  assign o_wr       = wr_c;
  assign o_tx_start = tx_start_c;
  assign o_wdata    = wdata_c;
`else
  assign o_wr       = 1'b0;
  assign o_tx_start = 1'b0;
  assign o_wdata    = '0;

  // Tx handshake and ACK byte have no function in this build.
  logic unused_tx;
  assign unused_tx = ^{i_tx_done, ACK_BYTE};
`endif

endmodule

// File: tb/tb_du_dmem_rx.sv
module tb_du_dmem_rx;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_rx_done, i_tx_done;
  logic [7:0]  i_rx_data;
  logic        o_done, o_rd, o_dmem_wr, o_wr, o_tx_start;
  logic [1:0]  o_dmem_wsize;
  logic [31:0] o_dmem_waddr, o_dmem_wdata;
  logic [7:0]  o_wdata;

  du_dmem_rx #(.NB_DATA(32), .NB_UART_DATA(8), .ACK_BYTE(8'h06)) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .i_tx_done(i_tx_done),
    .o_done(o_done), .o_rd(o_rd), .o_dmem_wr(o_dmem_wr),
    .o_dmem_wsize(o_dmem_wsize), .o_dmem_waddr(o_dmem_waddr),
    .o_dmem_wdata(o_dmem_wdata), .o_wr(o_wr), .o_tx_start(o_tx_start),
    .o_wdata(o_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          gap;
  } vec_t;

  int   checks = 0, errors = 0;
  int   cyc = 0, last_pop_cyc = 0;
  int   rd_cnt = 0, wr_seen = 0, done_cnt = 0, txwr_cnt = 0, txst_cnt = 0;
  int   gap_cnt = 0, tx_cnt = 0;
  bit   gap_en = 0, ack_wait = 0, popped;
  logic [7:0] rx_q[$];
  wr_t        exp_q[$];
  vec_t       vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: monitor outputs on the falling edge, then advance the FIFO
  // and Tx models just after the rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    popped = 0;
    if (o_rd) begin
      rd_cnt++;
      chk("rd_with_data", i_rx_done, 1'b1);
`ifdef DU_DMEM_RX_ACK_EN
      chk("rd_during_ack", ack_wait, 1'b0);
`endif
      popped       = i_rx_done;
      last_pop_cyc = cyc;
    end
    if (o_dmem_wr) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", o_dmem_waddr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", o_dmem_waddr, e.addr);
        chk("wr_data", o_dmem_wdata, e.data);
        chk("wr_size", o_dmem_wsize, 2'b11);
        chk("wr_latency", cyc - last_pop_cyc, 2);
      end
    end
    if (o_done) done_cnt++;
    if (o_tx_start) txst_cnt++;
    if (o_wr) begin
      txwr_cnt++;
      chk("ack_byte", o_wdata, 8'h06);
      chk("ack_start", o_tx_start, 1'b1);
      ack_wait = 1;
      tx_cnt   = 4;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (popped) begin
      void'(rx_q.pop_front());
      gap_cnt = gap_en ? $urandom_range(6, 2) : 0;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    i_rx_done = (rx_q.size() > 0) && (gap_cnt == 0);
    i_rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    i_tx_done = 1'b0;
    if (ack_wait) begin
      if (tx_cnt > 0) tx_cnt--;
      else begin
        i_tx_done = 1'b1;
        ack_wait  = 0;
      end
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) rx_q.push_back(w[8*k +: 8]);
  endtask

  task automatic load_pair(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    load_word(a);
    load_word(d);
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rx_q.size() > 0 || exp_q.size() > 0 || ack_wait) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", n < budget, 1'b1);
    repeat (8) tick();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h1111_1111, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h2222_2222, 1'b0};
    vecs[3] = '{32'h0000_000C, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'h0000_0100, 32'hA5A5_5A5A, 1'b1};
    vecs[5] = '{32'h8000_0001, 32'h1234_5678, 1'b1};

    i_rst = 1'b1; i_start = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00; i_tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {o_done, o_rd, o_dmem_wr, o_dmem_wsize, o_wr, o_tx_start, o_wdata}, 0);
    chk("rst_waddr", o_dmem_waddr, 0);
    chk("rst_wdata", o_dmem_wdata, 0);
    @(posedge clk);
    #1;

    // Session 1: table of pairs, first four back-to-back, then gapped ones.
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      gap_en = vecs[i].gap;
      load_pair(vecs[i].addr, vecs[i].data);
      if (i == 0) begin
        drain(200);
        chk("first_pair_pops", rd_cnt, 8);
      end else if (i == 3 || vecs[i].gap) begin
        drain(600);
      end
    end
    gap_en = 0;
    load_word(32'hFFFF_FFFF);
    drain(200);
    chk("done_pulses", done_cnt, 1);
    chk("session1_pops", rd_cnt, 8 * 6 + 4);
    chk("session1_writes", wr_seen, 6);

    // Back in IDLE: a waiting byte must stay in the FIFO.
    rx_q.push_back(8'h55);
    repeat (10) tick();
    chk("idle_no_pop", rx_q.size(), 1);
    rx_q.delete();
    tick();

    // Session 2: reset after two address bytes, then a clean pair.
    pulse_start();
    rx_q.push_back(8'hAA);
    rx_q.push_back(8'hBB);
    drain(100);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    pulse_start();
    load_pair(32'h0000_0020, 32'h0000_0001);
    drain(200);
    chk("total_writes", wr_seen, 7);
    chk("done_not_repeated", done_cnt, 1);
`ifdef DU_DMEM_RX_ACK_EN
    chk("ack_count", txwr_cnt, wr_seen);
    chk("tx_start_count", txst_cnt, wr_seen);
`else
    chk("no_tx_wr", txwr_cnt, 0);
    chk("no_tx_start", txst_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
